// File: rtl/udp_pkg.sv
// Shared UDP definitions for the transmit and receive paths: header layout,
// FSM encoding and the header byte serialiser.
package udp_pkg;

  localparam int UDP_HDR_BYTES   = 8;
  localparam int UDP_MAX_PAYLOAD = 1472;

  // Byte offsets of the header fields within the 8-byte UDP header.
  localparam int UDP_SRC_PORT_OFF = 0;
  localparam int UDP_DST_PORT_OFF = 2;
  localparam int UDP_LEN_OFF      = 4;
  localparam int UDP_CSUM_OFF     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DROP
  } udp_state_e;

  function automatic logic [7:0] udp_hdr_byte(input logic [15:0] src_port,
                                              input logic [15:0] dst_port,
                                              input logic [15:0] udp_len,
                                              input logic [2:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (int'(idx))
      UDP_SRC_PORT_OFF:     b = src_port[15:8];
      UDP_SRC_PORT_OFF + 1: b = src_port[7:0];
      UDP_DST_PORT_OFF:     b = dst_port[15:8];
      UDP_DST_PORT_OFF + 1: b = dst_port[7:0];
      UDP_LEN_OFF:          b = udp_len[15:8];
      UDP_LEN_OFF + 1:      b = udp_len[7:0];
      UDP_CSUM_OFF,
      UDP_CSUM_OFF + 1:     b = 8'h00;
      default:              b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_xmit_if.sv
// Header request, payload stream and IP-side output stream of the UDP transmitter.
interface udp_xmit_if;

  logic        hdr_valid_in;
  logic        hdr_ready_out;
  logic [15:0] src_port_in;
  logic [15:0] dest_port_in;
  logic [15:0] payload_length_in;

  logic [7:0]  udpdata_tdata_in;
  logic        udpdata_tvalid_in;
  logic        udpdata_tlast_in;
  logic        udpdata_tready_out;

  logic [7:0]  udp_axis_tdata_out;
  logic        udp_axis_tvalid_out;
  logic        udp_axis_tlast_out;
  logic        udp_axis_tready_in;

  logic [15:0] udp_length_out;
  logic        busy_out;
  logic        len_err_out;

  // Application / IP-layer side.
  modport master (
    output hdr_valid_in, src_port_in, dest_port_in, payload_length_in,
    output udpdata_tdata_in, udpdata_tvalid_in, udpdata_tlast_in,
    output udp_axis_tready_in,
    input  hdr_ready_out, udpdata_tready_out,
    input  udp_axis_tdata_out, udp_axis_tvalid_out, udp_axis_tlast_out,
    input  udp_length_out, busy_out, len_err_out
  );

  // Transmitter side.
  modport slave (
    input  hdr_valid_in, src_port_in, dest_port_in, payload_length_in,
    input  udpdata_tdata_in, udpdata_tvalid_in, udpdata_tlast_in,
    input  udp_axis_tready_in,
    output hdr_ready_out, udpdata_tready_out,
    output udp_axis_tdata_out, udp_axis_tvalid_out, udp_axis_tlast_out,
    output udp_length_out, busy_out, len_err_out
  );

endinterface

// File: rtl/udp_axis_oreg.sv
// Single-stage registered AXI-Stream output; adv_o says the stage can take a
// new beat this cycle, giving full 1 byte/cycle throughput.
module udp_axis_oreg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_valid_i,
  input  logic [7:0] load_data_i,
  input  logic       load_last_i,
  input  logic       tready_i,
  output logic       adv_o,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  output logic       tlast_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       last_q;

  assign adv_o = !valid_q || tready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else if (adv_o) begin
      valid_q <= load_valid_i;
      data_q  <= load_data_i;
      last_q  <= load_last_i;
    end
  end

  assign tdata_o  = data_q;
  assign tvalid_o = valid_q;
  assign tlast_o  = last_q;

endmodule

// File: rtl/udp_xmit.sv
// UDP transmit path: serialises an 8-byte header (checksum 0) followed by the
// payload, trimming or flagging payloads that disagree with the declared length.
module udp_xmit
  import udp_pkg::*;
#(
  parameter int MAX_PAYLOAD = UDP_MAX_PAYLOAD,
  parameter bit DEBUG       = 1'b0
) (
  input logic       clk,
  input logic       reset_n,
  udp_xmit_if.slave xmit
);

  localparam logic [2:0] LastHdrIdx = 3'(UDP_HDR_BYTES - 1);

  udp_state_e  state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] pay_len_q, pay_len_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic        len_err_q, len_err_d;

  logic        hdr_ready;
  logic        pay_ready;
  logic        adv;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      rem_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pay_len_q <= '0;
      udp_len_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      rem_q     <= rem_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      pay_len_q <= pay_len_d;
      udp_len_q <= udp_len_d;
      len_err_q <= len_err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    rem_d      = rem_q;
    src_d      = src_q;
    dst_d      = dst_q;
    pay_len_d  = pay_len_q;
    udp_len_d  = udp_len_q;
    len_err_d  = 1'b0;
    hdr_ready  = 1'b0;
    pay_ready  = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hdr_ready = 1'b1;
        if (xmit.hdr_valid_in) begin
          src_d     = xmit.src_port_in;
          dst_d     = xmit.dest_port_in;
          pay_len_d = xmit.payload_length_in;
          udp_len_d = xmit.payload_length_in + 16'(UDP_HDR_BYTES);
          hdr_cnt_d = '0;
          if (xmit.payload_length_in > 16'(MAX_PAYLOAD)) begin
            len_err_d = 1'b1;
            state_d   = ST_DROP;
          end else begin
            state_d   = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (adv) begin
          load_valid = 1'b1;
          load_data  = udp_hdr_byte(src_q, dst_q, udp_len_q, hdr_cnt_q);
          hdr_cnt_d  = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == LastHdrIdx) begin
            load_last = (pay_len_q == '0);
            rem_d     = pay_len_q;
            state_d   = (pay_len_q == '0) ? ST_IDLE : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        pay_ready = adv;
        if (adv && xmit.udpdata_tvalid_in) begin
          load_valid = 1'b1;
          load_data  = xmit.udpdata_tdata_in;
          load_last  = (rem_q == 16'd1) || xmit.udpdata_tlast_in;
          rem_d      = rem_q - 16'd1;
          if (xmit.udpdata_tlast_in) begin
            // Short payload ends the datagram early; no padding is inserted.
            len_err_d = (rem_q != 16'd1);
            state_d   = ST_IDLE;
          end else if (rem_q == 16'd1) begin
            len_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        pay_ready = 1'b1;
        if (xmit.udpdata_tvalid_in && xmit.udpdata_tlast_in) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  udp_axis_oreg u_oreg (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .tready_i     (xmit.udp_axis_tready_in),
    .adv_o        (adv),
    .tdata_o      (xmit.udp_axis_tdata_out),
    .tvalid_o     (xmit.udp_axis_tvalid_out),
    .tlast_o      (xmit.udp_axis_tlast_out)
  );

  // Held low while reset is applied so every output reads 0 in reset.
  assign xmit.hdr_ready_out      = hdr_ready & reset_n;
  assign xmit.udpdata_tready_out = pay_ready;
  assign xmit.udp_length_out     = udp_len_q;
  assign xmit.busy_out           = (state_q != ST_IDLE);
  assign xmit.len_err_out        = len_err_q;

  if (DEBUG) begin : g_ila
    (* mark_debug = "true" *) logic [9:0] ila_probe;
    assign ila_probe = {xmit.udp_axis_tvalid_out, xmit.udp_axis_tlast_out,
                        xmit.udp_axis_tdata_out};
  end

endmodule
